// File: rtl/alu_fun_dispatch.sv
// Sequential ALU function dispatcher: accepts one operation per handshake, pulses the selected
// unit's one-hot enable, then waits for its done or a timeout. Macro ALU_DISPATCH_CNT_EN adds OP_CNT.
module alu_fun_dispatch #(
    parameter  int FUN_W     = 2,
    parameter  int DATA_W    = 16,
    parameter  int TIMEOUT   = 15,
    parameter  int CNT_W     = 8,
    localparam int NUM_UNITS = 2 ** FUN_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [FUN_W-1:0]     ALU_FUN,
    input  logic [DATA_W-1:0]    A,
    input  logic [DATA_W-1:0]    B,
    output logic [NUM_UNITS-1:0] UNIT_EN,
    output logic [DATA_W-1:0]    OP_A,
    output logic [DATA_W-1:0]    OP_B,
    output logic [FUN_W-1:0]     FUN_Q,
    input  logic [NUM_UNITS-1:0] UNIT_DONE,
    output logic                 CMPL,
    output logic                 TIMEOUT_ERR,
    output logic                 BUSY
`ifdef ALU_DISPATCH_CNT_EN
    ,
    output logic [NUM_UNITS*CNT_W-1:0] OP_CNT
`endif
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    if (TIMEOUT < 1 || CNT_W < 1) begin : g_bad_param
        $error("alu_fun_dispatch: TIMEOUT and CNT_W must both be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0]    op_a_q, op_a_d;
    logic [DATA_W-1:0]    op_b_q, op_b_d;
    logic [FUN_W-1:0]     fun_sel_q, fun_sel_d;
    logic [NUM_UNITS-1:0] unit_en_q, unit_en_d;
    logic                 cmpl_q, cmpl_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 busy_q, busy_d;
    logic                 sel_done;

    // Only the unit owning the operation in flight can complete it.
    assign sel_done = UNIT_DONE[fun_sel_q];

    always_comb begin
        // NOTE: every next-value signal gets a default first, so no latch is inferred.
        state_d       = state_q;
        timer_d       = timer_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        fun_sel_d     = fun_sel_q;
        unit_en_d     = '0;
        cmpl_d        = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    op_a_d    = A;
                    op_b_d    = B;
                    fun_sel_d = ALU_FUN;
                    unit_en_d = NUM_UNITS'(1) << ALU_FUN;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = TMR_W'(TIMEOUT);
                if (sel_done) begin
                    cmpl_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Done is checked before expiry so a last-cycle done still completes.
                if (sel_done) begin
                    cmpl_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (timer_q == TMR_W'(1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state is written only with non-blocking assignments.
        if (RST) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            fun_sel_q     <= '0;
            unit_en_q     <= '0;
            cmpl_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            fun_sel_q     <= fun_sel_d;
            unit_en_q     <= unit_en_d;
            cmpl_q        <= cmpl_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    assign IN_READY    = (state_q == ST_IDLE);
    assign UNIT_EN     = unit_en_q;
    assign OP_A        = op_a_q;
    assign OP_B        = op_b_q;
    assign FUN_Q       = fun_sel_q;
    assign CMPL        = cmpl_q;
    assign TIMEOUT_ERR = timeout_err_q;
    assign BUSY        = busy_q;

`ifdef ALU_DISPATCH_CNT_EN
    logic [NUM_UNITS*CNT_W-1:0] op_cnt_q, op_cnt_d;

    // Counter moves on the same edge that raises CMPL; saturates rather than wrapping.
    always_comb begin
        op_cnt_d = op_cnt_q;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (cmpl_d && (fun_sel_q == FUN_W'(i)) && (op_cnt_q[i*CNT_W +: CNT_W] != '1)) begin
                op_cnt_d[i*CNT_W +: CNT_W] = op_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            op_cnt_q <= '0;
        end else begin
            op_cnt_q <= op_cnt_d;
        end
    end

    assign OP_CNT = op_cnt_q;
`endif

endmodule

// File: doc/alu_fun_dispatch.md
Name: alu_fun_dispatch

Overview:
Parametrised, sequential successor to the ALU function decoder. Accepts one operation (function code plus two operands) per valid/ready handshake and latches it. It then issues a one-cycle one-hot enable to the selected execution unit (arith/logic/cmp/shift for FUN_W=2) and waits for that unit's done. It reports completion or a timeout. Sits between the ALU top-level operand/opcode inputs and the execution units, replacing the combinational enable decode.

Parameters:
FUN_W, 2, function-code width; NUM_UNITS = 2**FUN_W one-hot enable lines
DATA_W, 16, operand width (signed data passed through untouched)
TIMEOUT, 15, max cycles after the UNIT_EN cycle to wait for done; legal range >= 1
CNT_W, 8, per-unit completion counter width (used only with ALU_DISPATCH_CNT_EN)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous, active-high reset
IN_VALID  input  1  operation request valid
IN_READY  output  1  block can accept an operation
ALU_FUN  input  FUN_W  function code; selects unit index
A  input  DATA_W  operand A
B  input  DATA_W  operand B
UNIT_EN  output  NUM_UNITS  one-hot unit enable, one-cycle pulse
OP_A  output  DATA_W  latched operand A to units
OP_B  output  DATA_W  latched operand B to units
FUN_Q  output  FUN_W  latched function code of the operation in flight
UNIT_DONE  input  NUM_UNITS  per-unit done, bit i from unit i
CMPL  output  1  one-cycle pulse: operation completed
TIMEOUT_ERR  output  1  one-cycle pulse: selected unit never returned done
BUSY  output  1  operation in flight (state != IDLE)

Behaviour:
- Reset (RST high at an edge): state IDLE. UNIT_EN=0, OP_A=0, OP_B=0, FUN_Q=0, CMPL=0, TIMEOUT_ERR=0, BUSY=0, timer=0. RST overrides all other inputs, including mid-operation. The aborted operation produces no CMPL and no TIMEOUT_ERR.
- States: IDLE, ISSUE, WAIT. All outputs are registered except IN_READY, which is combinational: IN_READY = (state==IDLE).
- IDLE: on IN_VALID & IN_READY at edge k: latch A->OP_A, B->OP_B, ALU_FUN->FUN_Q; go to ISSUE. Without IN_VALID, stay in IDLE.
- ISSUE (cycle k+1, exactly one cycle): UNIT_EN = 1 << FUN_Q, all other bits 0. Timer loaded with TIMEOUT.
  - If UNIT_DONE[FUN_Q] is sampled high at the end of ISSUE: go to IDLE and pulse CMPL in cycle k+2.
  - Otherwise go to WAIT.
- WAIT: UNIT_EN=0.
  - UNIT_DONE[FUN_Q] high: go to IDLE; CMPL=1 for the next cycle.
  - Else if timer==1: go to IDLE; TIMEOUT_ERR=1 for the next cycle.
  - Else: timer decrements.
  - Done and timer expiry in the same cycle: done wins; CMPL only.
- Window: done is honoured in cycles k+1 through k+1+TIMEOUT. If absent throughout, TIMEOUT_ERR is high in cycle k+2+TIMEOUT.
- CMPL/TIMEOUT_ERR are asserted in the first IDLE cycle. IN_READY is high in that same cycle, so a new request can be accepted there. Minimum issue interval is 2 cycles.
- OP_A, OP_B and FUN_Q hold from ISSUE until the next accept. They are unchanged while IN_VALID toggles during ISSUE/WAIT.
- UNIT_DONE bits of unselected units, and any done while in IDLE, are ignored.
- ALU_FUN is always in range (NUM_UNITS = 2**FUN_W); no illegal code exists.
- UNIT_EN is never multi-hot, and is never high outside ISSUE.
- BUSY = 1 in ISSUE and WAIT.

Optional Feature:
Macro ALU_DISPATCH_CNT_EN.
- Defined: adds output OP_CNT, width NUM_UNITS*CNT_W. Slice [i*CNT_W +: CNT_W] counts CMPL events for unit i.
  - Increments in the same cycle CMPL is asserted.
  - Timeouts are not counted.
  - Saturates at all ones; no wrap.
  - Cleared to 0 by RST.
- Undefined: OP_CNT port and counters absent; all other behaviour identical.

Test Plan:
- Reset: RST high 2 cycles with IN_VALID=1, ALU_FUN=2 -> UNIT_EN=0, BUSY=0, CMPL=0, OP_A=0, IN_READY=1 after release.
- Basic issue: accept ALU_FUN=2, A=16'h8001, B=16'h0003 at edge k. UNIT_DONE[2] high in cycle k+3 -> UNIT_EN=4'b0100 only in cycle k+1; CMPL in cycle k+4; OP_A=16'h8001 held; IN_READY low in cycles k+1..k+3.
- Zero-latency unit: ALU_FUN=0, UNIT_DONE[0] tied high -> UNIT_EN=4'b0001 in k+1, CMPL in k+2. A second request accepted in k+2 gives UNIT_EN again in k+3.
- Timeout with stray done: TIMEOUT=15, ALU_FUN=3, only UNIT_DONE[1] pulsed -> no CMPL; TIMEOUT_ERR in cycle k+17. Done arriving exactly in cycle k+16 gives CMPL in k+17 and no TIMEOUT_ERR.
- Reset mid-op: RST in WAIT cycle k+5 -> IDLE at k+6; no CMPL/TIMEOUT_ERR even if UNIT_DONE fires; OP_A=0.
- With ALU_DISPATCH_CNT_EN, CNT_W=2: 5 completions on unit 1, 1 timeout on unit 0 -> OP_CNT slice1=3 (saturated), slice0=0.
